// File: rtl/axi4_native_bridge_v2.sv
// axi4_native_bridge_v2: AXI4 slave bridged onto a native memory-controller command/data port
module axi4_native_bridge_v2_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
  // storage is unreset; occupancy is defined by the pointers alone
  always_ff @(posedge clock)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  // pointer advance; reset empties the queue
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
endmodule

module axi4_native_bridge_v2 #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_STEP  = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     axi_awid,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ID_WIDTH-1:0]     axi_arid,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [ID_WIDTH-1:0]     axi_rid,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_end,
  output logic                    app_wdf_wren,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  input  logic                    init_calib_complete
);
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [2:0] {CALIB, IDLE, WR_DATA, WR_DRAIN, WR_RESP, RD} state_t;
  state_t state;
  logic rr, err;
  logic [ID_WIDTH-1:0] id;
  logic [ADDR_WIDTH-1:0] base;
  logic [8:0] beats, pushed, cmd_cnt, popped;
  logic aw_hs, ar_hs, w_hs, cmd_hs, wpop, rpop, clr, wr_st;
  logic wfull, wempty, rfull, rempty;
  logic [DATA_WIDTH+SW-1:0] whead;
  assign axi_awready  = state == IDLE && axi_awvalid && (!axi_arvalid || !rr);
  assign axi_arready  = state == IDLE && axi_arvalid && (!axi_awvalid || rr);
  assign axi_wready   = state == WR_DATA && pushed < beats && !wfull;
  assign aw_hs        = axi_awvalid && axi_awready;
  assign ar_hs        = axi_arvalid && axi_arready;
  assign w_hs         = axi_wvalid && axi_wready;
  assign wr_st        = state == WR_DATA || state == WR_DRAIN;
  assign app_en       = (wr_st && cmd_cnt < pushed) ||
                        (state == RD && cmd_cnt < beats && 32'(cmd_cnt - popped) < FIFO_DEPTH);
  assign app_addr     = base + ADDR_WIDTH'(cmd_cnt) * ADDR_WIDTH'(ADDR_STEP);
  assign app_cmd      = {2'b00, state == RD};
  assign cmd_hs       = app_en && app_rdy;
  assign app_wdf_wren = !wempty;
  assign app_wdf_end  = 1'b1;
  assign {app_wdf_data, app_wdf_mask} = whead;
  assign wpop         = app_wdf_wren && app_wdf_rdy;
  assign axi_bvalid   = state == WR_RESP;
  assign axi_bid      = id;
  assign axi_bresp    = {err, 1'b0};
  assign axi_rvalid   = !rempty;
  assign axi_rid      = id;
  assign axi_rresp    = 2'b00;
  assign axi_rlast    = axi_rvalid && popped == beats - 9'd1;
  assign rpop         = axi_rvalid && axi_rready;
  assign clr          = (state == WR_RESP && axi_bready) || (state == RD && rpop && axi_rlast);

  axi4_native_bridge_v2_fifo #(.W(DATA_WIDTH + SW), .D(FIFO_DEPTH)) u_wfifo (
    .clock(clock), .rst(rst), .push(w_hs), .din({axi_wdata, ~axi_wstrb}), .pop(wpop),
    .dout(whead), .empty(wempty), .full(wfull));

  axi4_native_bridge_v2_fifo #(.W(DATA_WIDTH), .D(FIFO_DEPTH)) u_rfifo (
    .clock(clock), .rst(rst), .push(app_rd_data_valid && !rfull), .din(app_rd_data), .pop(rpop),
    .dout(axi_rdata), .empty(rempty), .full(rfull));

  // burst sequencing: command latch, beat counters, wlast checking and state transitions
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      state   <= CALIB;
      rr      <= 1'b0;
      err     <= 1'b0;
      id      <= '0;
      base    <= '0;
      beats   <= '0;
      pushed  <= '0;
      cmd_cnt <= '0;
      popped  <= '0;
    end else begin
      if (aw_hs || ar_hs) begin
        rr    <= ~rr;
        id    <= aw_hs ? axi_awid : axi_arid;
        base  <= aw_hs ? axi_awaddr : axi_araddr;
        beats <= {1'b0, aw_hs ? axi_awlen : axi_arlen} + 9'd1;
      end
      pushed  <= clr ? '0 : pushed + 9'(w_hs);
      cmd_cnt <= clr ? '0 : cmd_cnt + 9'(cmd_hs);
      popped  <= clr ? '0 : popped + 9'(rpop);
      err     <= clr ? 1'b0 : err | (w_hs && (axi_wlast != (pushed == beats - 9'd1)));
      case (state)
        CALIB:    state <= init_calib_complete ? IDLE : CALIB;
        IDLE:     state <= aw_hs ? WR_DATA : ar_hs ? RD : IDLE;
        WR_DATA:  state <= (w_hs && pushed == beats - 9'd1) ? WR_DRAIN : WR_DATA;
        WR_DRAIN: state <= (cmd_cnt == beats && wempty) ? WR_RESP : WR_DRAIN;
        WR_RESP:  state <= axi_bready ? IDLE : WR_RESP;
        RD:       state <= (rpop && axi_rlast) ? IDLE : RD;
        default:  state <= CALIB;
      endcase
    end
endmodule

// File: tb/tb_axi4_native_bridge_v2.sv
// tb_axi4_native_bridge_v2: directed self-checking bench for the AXI4-to-native bridge
module tb_axi4_native_bridge_v2;
  logic clock, rst;
  logic [3:0] axi_awid, axi_bid, axi_arid, axi_rid;
  logic [26:0] axi_awaddr, axi_araddr, app_addr;
  logic [7:0] axi_awlen, axi_arlen;
  logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic [255:0] axi_wdata, axi_rdata, app_wdf_data, app_rd_data;
  logic [31:0] axi_wstrb, app_wdf_mask;
  logic [1:0] axi_bresp, axi_rresp;
  logic axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic [2:0] app_cmd;
  logic app_en, app_rdy, app_wdf_end, app_wdf_wren, app_wdf_rdy, app_rd_data_valid, init_calib_complete;
  int checks = 0, failures = 0, rd_n = 0, t = 0, nl = 0;
  logic [29:0] cq[$];
  logic [26:0] pend[$];
  logic [31:0] wm_q[$];
  logic [255:0] wd_q[$], rd_q[$];
  logic rl_q[$];
  logic [3:0] ri_q[$];

  axi4_native_bridge_v2 dut (
    .clock(clock), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_end(app_wdf_end), .app_wdf_wren(app_wdf_wren), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .init_calib_complete(init_calib_complete));

  initial clock = 0;
  always #5 clock = ~clock;

  function automatic logic [255:0] rdf(input logic [26:0] a);
    return {8{5'b0, a}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_logs();
    cq.delete(); wm_q.delete(); wd_q.delete(); rd_q.delete(); rl_q.delete(); ri_q.delete();
    rd_n = 0;
  endtask

  task automatic cmd(input bit rd, input logic [3:0] i, input logic [26:0] a, input logic [7:0] len);
    int k = 0;
    if (rd) begin axi_arid = i; axi_araddr = a; axi_arlen = len; axi_arvalid = 1; end
    else begin axi_awid = i; axi_awaddr = a; axi_awlen = len; axi_awvalid = 1; end
    #1;
    while (!(rd ? axi_arready : axi_awready) && k < 100) begin @(negedge clock); #1; k++; end
    chk(rd ? "ar_accept" : "aw_accept", rd ? axi_arready : axi_awready, 1);
    @(negedge clock);
    axi_arvalid = 0;
    axi_awvalid = 0;
  endtask

  task automatic wbeats(input int n, input int last);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      axi_wvalid = 1; axi_wdata = {8{32'hD00D_0000 + 32'(i)}}; axi_wstrb = '1; axi_wlast = (i == last);
      #1;
      while (!axi_wready && k < 100) begin @(negedge clock); #1; k++; end
      @(negedge clock);
    end
    axi_wvalid = 0;
    axi_wlast = 0;
    chk("w_accept", k < 100, 1);
  endtask

  task automatic bchk(input logic [3:0] i, input logic [1:0] r);
    int k = 0;
    #1;
    while (!axi_bvalid && k < 200) begin @(negedge clock); #1; k++; end
    chk("b_valid", axi_bvalid, 1);
    chk("b_id", axi_bid, i);
    chk("b_resp", axi_bresp, r);
    axi_bready = 1;
    @(negedge clock);
    axi_bready = 0;
  endtask

  // native-side model: logs handshakes and queues read commands for data return
  always @(negedge clock) begin
    #2;
    if (!rst) begin
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b001) begin rd_n++; pend.push_back(app_addr); end
        else cq.push_back({app_cmd, app_addr});
      end
      if (app_wdf_wren && app_wdf_rdy) begin wm_q.push_back(app_wdf_mask); wd_q.push_back(app_wdf_data); end
      if (axi_rvalid && axi_rready) begin rd_q.push_back(axi_rdata); rl_q.push_back(axi_rlast); ri_q.push_back(axi_rid); end
    end
  end

  // read data returns one cycle after each accepted read command
  always @(negedge clock)
    if (rst) begin
      pend.delete();
      app_rd_data_valid = 0;
    end else if (pend.size() > 0) begin
      app_rd_data = rdf(pend.pop_front());
      app_rd_data_valid = 1;
    end else app_rd_data_valid = 0;

  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    {axi_awid, axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready} = '0;
    {axi_arid, axi_araddr, axi_arlen, axi_arvalid, axi_rready, init_calib_complete} = '0;
    app_rd_data = '0;
    rst = 1; app_rdy = 1; app_wdf_rdy = 1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_awready", axi_awready, 0);
    chk("rst_arready", axi_arready, 0);
    chk("rst_wready", axi_wready, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_rlast", axi_rlast, 0);
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_bid", axi_bid, 0);
    chk("rst_rid", axi_rid, 0);
    chk("rst_bresp", axi_bresp, 0);
    chk("rst_rresp", axi_rresp, 0);
    @(negedge clock);
    rst = 0;
    axi_awid = 5; axi_awaddr = 27'h100; axi_awlen = 3; axi_awvalid = 1;
    repeat (3) begin @(negedge clock); #1; chk("calib_block", axi_awready, 0); end
    @(negedge clock);
    init_calib_complete = 1;
    #1;
    chk("calib_still", axi_awready, 0);
    @(negedge clock);
    #1;
    chk("aw_first_idle", axi_awready, 1);
    @(negedge clock);
    axi_awvalid = 0;
    init_calib_complete = 0;
    clr_logs();
    wbeats(4, 3);
    bchk(5, 2'b00);
    chk("wr4_ncmd", cq.size(), 4);
    chk("wr4_nbeat", wd_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr4_cmd_addr", cq[i], {3'b000, 27'h100 + 27'(8 * i)});
      chk("wr4_mask", wm_q[i], 0);
      chk("wr4_data", wd_q[i], {8{32'hD00D_0000 + 32'(i)}});
    end
    clr_logs();
    cmd(0, 3, 27'h200, 1);
    wbeats(2, 0);
    bchk(3, 2'b10);
    chk("wlast_ncmd", cq.size(), 2);
    chk("wlast_nbeat", wd_q.size(), 2);
    clr_logs();
    cmd(0, 7, 27'h7FF_FFF8, 1);
    wbeats(2, 1);
    bchk(7, 2'b00);
    chk("wrap_addr0", cq[0], {3'b000, 27'h7FF_FFF8});
    chk("wrap_addr1", cq[1], 0);
    clr_logs();
    axi_rready = 0;
    cmd(1, 9, 27'h2000, 255);
    repeat (300) @(negedge clock);
    #1;
    chk("rd_credit_cmds", rd_n, 64);
    chk("rd_stall_rvalid", axi_rvalid, 1);
    chk("rd_stall_en", app_en, 0);
    chk("rd_stall_rlast", axi_rlast, 0);
    axi_rready = 1;
    t = 0;
    while (rd_q.size() < 256 && t < 3000) begin @(negedge clock); #3; t++; end
    @(negedge clock);
    axi_rready = 0;
    chk("rd_nbeat", rd_q.size(), 256);
    chk("rd_ncmd", rd_n, 256);
    nl = 0;
    foreach (rl_q[i]) nl += int'(rl_q[i]);
    chk("rd_rlast_count", nl, 1);
    chk("rd_rlast_final", rl_q[255], 1);
    chk("rd_data0", rd_q[0], rdf(27'h2000));
    chk("rd_data64", rd_q[64], rdf(27'h2200));
    chk("rd_data255", rd_q[255], rdf(27'h27F8));
    chk("rd_rid", ri_q[255], 9);
    clr_logs();
    cmd(1, 2, 27'h3000, 7);
    repeat (20) @(negedge clock);
    #1;
    chk("abort_pre_rvalid", axi_rvalid, 1);
    rst = 1;
    init_calib_complete = 1;
    #1;
    chk("abort_rvalid", axi_rvalid, 0);
    chk("abort_app_en", app_en, 0);
    repeat (2) @(negedge clock);
    rst = 0;
    repeat (10) @(negedge clock);
    #1;
    chk("abort_post_rvalid", axi_rvalid, 0);
    chk("abort_post_bvalid", axi_bvalid, 0);
    @(negedge clock);
    clr_logs();
    axi_awid = 1; axi_awaddr = 27'h400; axi_awlen = 0; axi_awvalid = 1;
    axi_arid = 2; axi_araddr = 27'h500; axi_arlen = 0; axi_arvalid = 1;
    #1;
    chk("arb1_aw", axi_awready, 1);
    chk("arb1_ar", axi_arready, 0);
    @(negedge clock);
    axi_awvalid = 0;
    wbeats(1, 0);
    bchk(1, 2'b00);
    axi_awvalid = 1;
    #1;
    chk("arb2_ar", axi_arready, 1);
    chk("arb2_aw", axi_awready, 0);
    @(negedge clock);
    axi_awvalid = 0;
    axi_arvalid = 0;
    axi_rready = 1;
    t = 0;
    while (rd_q.size() == 0 && t < 100) begin @(negedge clock); #3; t++; end
    chk("arb_rd_nbeat", rd_q.size(), 1);
    chk("arb_rd_last", rl_q[0], 1);
    chk("arb_rd_data", rd_q[0], rdf(27'h500));
    chk("arb_rd_id", ri_q[0], 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
